iis_slave_rx: RTL

- I2S slave receiver. An external master drives the bit clock and word select; this block oversamples sck_i, ws_i and sd_i on pclk.
- Deserialises Philips-format I2S frames into left-aligned DATA_WIDTH-bit words, each tagged with its channel.
- Buffers words in a small internal FIFO. A valid/ready port drains the FIFO into the APB I2S peripheral's receive path, for slave-mode operation next to the existing master send/receive pair.

---
 rtl/iis_slave_rx.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/iis_slave_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : iis_slave_rx                                             |
// | Description : I2S (Philips format) slave receiver. Oversamples the     |
// |               external bit clock, word select and data on pclk. It     |
// |               deserialises each channel slot into a left-aligned       |
// |               DATA_WIDTH-bit word tagged with its channel, and buffers |
// |               the words in a small FIFO drained over valid/ready.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// | Ports                                                                  |
// |   pclk         in   system clock, all logic on its rising edge          |
// |   rst          in   synchronous active-high reset                       |
// |   en_i         in   receiver enable                                     |
// |   sck_i        in   external I2S bit clock (asynchronous)               |
// |   ws_i         in   external word select, 0 = left, 1 = right           |
// |   sd_i         in   external serial data, MSB first                     |
// |   data_o       out  head-of-FIFO word (last popped word when empty)     |
// |   chan_o       out  channel of data_o                                   |
// |   valid_o      out  FIFO not empty                                      |
// |   ready_i      in   consumer accepts data_o                             |
// |   overflow_o   out  sticky: a word was dropped on a full FIFO           |
// |   clr_ovf_i    in   clears overflow_o                                   |
// |   sample_cnt_o out  number of accepted pushes, wraps                    |
// +------------------------------------------------------------------------+
module iis_slave_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  sck_i,
  input  logic                  ws_i,
  input  logic                  sd_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  chan_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overflow_o,
  input  logic                  clr_ovf_i,
  output logic [CNT_WIDTH-1:0]  sample_cnt_o
);

  localparam int c_BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int c_IDX_W = $clog2(DATA_WIDTH);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_OCC_W = c_PTR_W + 1;
  localparam logic [c_BIT_W-1:0] c_BIT_MAX = c_BIT_W'(DATA_WIDTH);
  localparam logic [c_OCC_W-1:0] c_FULL    = c_OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronisers. sck carries a third stage for edge detection so
  // that ws/sd (two stages) line up with the detected rising edge.
  // ---------------------------------------------------------------------
  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_ws_s1,  r_ws_s2;
  logic r_sd_s1,  r_sd_s2;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_s3 <= 1'b0;
      r_ws_s1  <= 1'b0;
      r_ws_s2  <= 1'b0;
      r_sd_s1  <= 1'b0;
      r_sd_s2  <= 1'b0;
    end else begin
      r_sck_s1 <= sck_i;
      r_sck_s2 <= r_sck_s1;
      r_sck_s3 <= r_sck_s2;
      r_ws_s1  <= ws_i;
      r_ws_s2  <= r_ws_s1;
      r_sd_s1  <= sd_i;
      r_sd_s2  <= r_sd_s1;
    end
  end

  logic w_sck_rise;
  logic w_ws_now;
  logic w_sd_now;

  assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
  assign w_ws_now   = r_ws_s2;
  assign w_sd_now   = r_sd_s2;

  // ---------------------------------------------------------------------
  // Receive state
  // ---------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_next;
  logic                  r_ws_prev;
  logic                  r_ws_seen;   // r_ws_prev holds a real sample
  logic [DATA_WIDTH-1:0] r_shift;
  logic [c_BIT_W-1:0]    r_bitcnt;

  logic                  w_ws_change;
  logic                  w_capture;
  logic                  w_start;
  logic                  w_shift;
  logic                  w_push_req;
  logic [c_IDX_W-1:0]    w_bit_idx;
  logic [DATA_WIDTH-1:0] w_word;

  // The first edge after enabling only seeds ws_prev; comparing against a
  // stale value would lock onto a phantom transition mid-slot.
  assign w_ws_change = r_ws_seen & (w_ws_now != r_ws_prev);

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_push_req   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en_i) begin
          w_state_next = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (w_sck_rise) begin
          w_capture = 1'b1;
          if (w_ws_change) begin
            w_state_next = ST_RUN;
            w_start      = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_sck_rise) begin
          w_capture  = 1'b1;
          w_shift    = (r_bitcnt < c_BIT_MAX);
          // A ws change marks the bit just sampled as the previous LSB.
          w_push_req = w_ws_change;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (!en_i) begin
      w_state_next = ST_IDLE;
      w_capture    = 1'b0;
      w_start      = 1'b0;
      w_shift      = 1'b0;
      w_push_req   = 1'b0;
    end
  end

  // Bits land directly at their left-aligned position, so a short slot
  // leaves the low bits at zero and excess bits are simply not written.
  always_comb begin
    w_bit_idx = c_IDX_W'(DATA_WIDTH - 1 - int'(r_bitcnt));
    w_word    = r_shift;
    if (w_shift) begin
      w_word[w_bit_idx] = w_sd_now;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst || !en_i) begin
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_ws_prev <= 1'b0;
      r_ws_seen <= 1'b0;
    end else begin
      if (w_capture) begin
        r_ws_prev <= w_ws_now;
        r_ws_seen <= 1'b1;
      end
      if (w_start || w_push_req) begin
        r_shift  <= '0;
        r_bitcnt <= '0;
      end else if (w_shift) begin
        r_shift  <= w_word;
        r_bitcnt <= r_bitcnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic                  r_mem_chan [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_OCC_W-1:0]    r_count;
  logic [DATA_WIDTH-1:0] r_last_data;
  logic                  r_last_chan;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_sample_cnt;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == c_FULL);
  assign valid_o = (r_count != '0);
  assign w_pop   = valid_o & ready_i;
  // A simultaneous pop frees the head slot, so a full FIFO still accepts.
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & w_full & ~w_pop;

  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_word;
      r_mem_chan[r_wr_ptr] <= r_ws_prev;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_last_data  <= '0;
      r_last_chan  <= 1'b0;
      r_overflow   <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + 1'b1;
        r_sample_cnt <= r_sample_cnt + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_last_data <= r_mem_data[r_rd_ptr];
        r_last_chan <= r_mem_chan[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Set has priority over a clear in the same cycle.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Once empty, the outputs keep showing the word that was last consumed.
  assign data_o       = valid_o ? r_mem_data[r_rd_ptr] : r_last_data;
  assign chan_o       = valid_o ? r_mem_chan[r_rd_ptr] : r_last_chan;
  assign overflow_o   = r_overflow;
  assign sample_cnt_o = r_sample_cnt;

endmodule
`default_nettype wire
